ram_boot_loader: RTL

//  Upstream master of the 16 KiB system RAM. After reset, it receives a framed boot image on a

---
 rtl/ram_boot_loader_pkg.sv | 27 ++
 rtl/ram_boot_loader_bus_mux.sv | 34 +++
 rtl/ram_boot_loader.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ram_boot_loader_pkg.sv
// Shared types and constants for the RAM boot loader: FSM encoding, frame marker, RAM geometry.
// Pure declarations; no timing behaviour of its own.
package ram_boot_loader_pkg;

  localparam int       RAM_ADDR_W     = 14;
  localparam int       LEN_W          = 16;
  localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } boot_state_t;

  // A frame may fill the RAM exactly but never exceed it.
  function automatic logic len_too_big(input logic [LEN_W-1:0] len, input int addr_w);
    logic [LEN_W:0] cap;
    cap = (LEN_W+1)'(1) << addr_w;
    return {1'b0, len} > cap;
  endfunction

endpackage

// File: rtl/ram_boot_loader_bus_mux.sv
// RAM port owner select: loader while booting, CPU pass-through once the image is good.
// Latency: purely combinational. Backpressure: none, strobes pass straight through.
module boot_bus_mux
  import ram_boot_loader_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              sel_cpu,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_w,
  input  logic [7:0]        ld_wdata,
  input  logic              ld_wdata_oe,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_r,
  input  logic              cpu_w,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_wdata_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_r,
  output logic              ram_w,
  output logic [7:0]        ram_wdata,
  output logic              ram_wdata_oe
);

  // The loader never reads, so its read strobe is tied low.
  always_comb begin
    ram_addr     = sel_cpu ? cpu_addr     : ld_addr;
    ram_r        = sel_cpu & cpu_r;
    ram_w        = sel_cpu ? cpu_w        : ld_w;
    ram_wdata    = sel_cpu ? cpu_wdata    : ld_wdata;
    ram_wdata_oe = sel_cpu ? cpu_wdata_oe : ld_wdata_oe;
  end

endmodule

// File: rtl/ram_boot_loader.sv
// Loads a framed boot image from a byte stream into RAM, then hands the RAM port to the CPU.
// Latency: RAM write one cycle after each payload byte; in_ready drops during that write cycle.
module ram_boot_loader
  import ram_boot_loader_pkg::*;
#(
  parameter int                ADDR_W    = RAM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [7:0]        SYNC_BYTE = BOOT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_r,
  input  logic              cpu_w,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_wdata_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_r,
  output logic              ram_w,
  output logic [7:0]        ram_wdata,
  output logic              ram_wdata_oe,
  output logic              cpu_hold,
  output logic              boot_done,
  output logic              boot_err
);

  boot_state_t       state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  len;
  logic [7:0]        sum;
  logic [7:0]        wbuf;
  logic              accept_state;
  logic [LEN_W-1:0]  len_full;
  logic [LEN_W-1:0]  count_inc;
  logic              ld_write;

  assign len_full  = {in_data, len[7:0]};
  assign count_inc = count + LEN_W'(1);
  assign ld_write  = (state == ST_WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_SYNC;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept_state = 1'b0;
    case (state)
      ST_SYNC: begin
        accept_state = 1'b1;
        if (in_valid && in_data == SYNC_BYTE) state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        accept_state = 1'b1;
        if (in_valid) state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        accept_state = 1'b1;
        if (in_valid) begin
          if (len_too_big(len_full, ADDR_W)) state_nxt = ST_ERR;
          else if (len_full == '0)           state_nxt = ST_CSUM;
          else                               state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        accept_state = 1'b1;
        if (in_valid) state_nxt = ST_WRITE;
      end
      ST_WRITE: state_nxt = (count_inc == len) ? ST_CSUM : ST_DATA;
      ST_CSUM: begin
        accept_state = 1'b1;
        if (in_valid) state_nxt = (in_data == sum) ? ST_DONE : ST_ERR;
      end
      ST_DONE: state_nxt = ST_DONE;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_SYNC;
    endcase
  end

  // Datapath registers only move on an accepted byte or in the write cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= BASE_ADDR;
      count <= '0;
      len   <= '0;
      sum   <= '0;
      wbuf  <= '0;
    end else begin
      case (state)
        ST_LEN_LO: if (in_valid) len[7:0] <= in_data;
        ST_LEN_HI: if (in_valid) len <= len_full;
        ST_DATA: begin
          if (in_valid) begin
            wbuf <= in_data;
            sum  <= sum + in_data;
          end
        end
        ST_WRITE: begin
          addr  <= addr + ADDR_W'(1);
          count <= count_inc;
        end
        default: ;
      endcase
    end
  end

  // Gating with rst keeps in_ready low while reset is held, even though SYNC accepts.
  assign in_ready  = accept_state & ~rst;
  assign cpu_hold  = (state != ST_DONE);
  assign boot_done = (state == ST_DONE);
  assign boot_err  = (state == ST_ERR);

  boot_bus_mux #(.ADDR_W(ADDR_W)) u_bus_mux (
    .sel_cpu      (state == ST_DONE),
    .ld_addr      (addr),
    .ld_w         (ld_write),
    .ld_wdata     (wbuf),
    .ld_wdata_oe  (ld_write),
    .cpu_addr     (cpu_addr),
    .cpu_r        (cpu_r),
    .cpu_w        (cpu_w),
    .cpu_wdata    (cpu_wdata),
    .cpu_wdata_oe (cpu_wdata_oe),
    .ram_addr     (ram_addr),
    .ram_r        (ram_r),
    .ram_w        (ram_w),
    .ram_wdata    (ram_wdata),
    .ram_wdata_oe (ram_wdata_oe)
  );

endmodule
